// File: rtl/multicast_fanout.sv
// Egress replicator: buffers {flit, lane mask} in a small FIFO and presents the
// head flit on every masked lane; the head retires once all its lanes accept.
module multicast_fanout #(
  parameter int ValidBitPos = 81,
  parameter int lg_numprocs = 3,
  parameter int PORT_NUM    = 6,
  parameter int DEPTH       = 4,
  parameter int CNT_W       = 16,
  localparam int FlitChildWidth = ValidBitPos + 1 + lg_numprocs
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [FlitChildWidth-1:0]          in,
  input  logic [PORT_NUM-1:0]                in_dst_mask,
  input  logic                               in_valid,
  output logic                               in_avail,
  output logic [PORT_NUM*FlitChildWidth-1:0] out,
  output logic [PORT_NUM-1:0]                out_valid,
  input  logic [PORT_NUM-1:0]                out_avail,
  output logic                               drop_zero_mask,
  output logic [CNT_W-1:0]                   sent_count
);

  localparam int FCW    = FlitChildWidth;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_FW = $clog2(DEPTH + 1);
  localparam logic [CNT_FW-1:0] FULL = CNT_FW'(DEPTH);
  localparam logic [CNT_FW-1:0] ONE  = CNT_FW'(1);

  typedef enum logic {EMPTY, SERVE} state_t;

  state_t               state, state_nxt;
  logic [FCW-1:0]       flit_mem [DEPTH];
  logic [PORT_NUM-1:0]  mask_mem [DEPTH];
  logic [PTR_W-1:0]     rd_ptr, wr_ptr, rd_next;
  logic [CNT_FW-1:0]    count;
  logic [PORT_NUM-1:0]  pending, pending_nxt, xfer, pend_left;
  logic                 push, store, pop;
  logic [FCW-1:0]       head;

  always_comb begin
    in_avail    = rst && (count != FULL);
    push        = in_valid && in_avail;
    store       = push && (in_dst_mask != '0);
    xfer        = pending & out_avail;
    pend_left   = pending & ~xfer;
    rd_next     = rd_ptr + 1'b1;
    pop         = 1'b0;
    state_nxt   = state;
    pending_nxt = pending;
    case (state)
      EMPTY: begin
        if (store) begin
          state_nxt   = SERVE;
          pending_nxt = in_dst_mask;
        end
      end
      SERVE: begin
        if (pend_left == '0) begin
          pop = 1'b1;
          // The slot after the head may be the one being written right now,
          // so a sole survivor takes its mask straight from the input.
          if (count > ONE) begin
            pending_nxt = mask_mem[rd_next];
          end else if (store) begin
            pending_nxt = in_dst_mask;
          end else begin
            pending_nxt = '0;
            state_nxt   = EMPTY;
          end
        end else begin
          pending_nxt = pend_left;
        end
      end
      default: begin
        state_nxt   = EMPTY;
        pending_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= EMPTY;
      pending        <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      drop_zero_mask <= 1'b0;
      sent_count     <= '0;
    end else begin
      state          <= state_nxt;
      pending        <= pending_nxt;
      drop_zero_mask <= push && (in_dst_mask == '0);
      if (store) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr     <= rd_next;
        sent_count <= sent_count + 1'b1;
      end
      case ({store, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      flit_mem[wr_ptr] <= in;
      mask_mem[wr_ptr] <= in_dst_mask;
    end
  end

  assign head      = flit_mem[rd_ptr];
  assign out_valid = pending;

  always_comb begin
    out = '0;
    for (int unsigned p = 0; p < PORT_NUM; p++) begin
      out[p*FCW +: FCW] = pending[p] ? head : '0;
    end
  end

endmodule

// File: tb/tb_multicast_fanout.sv
// Directed bench for multicast_fanout with hand-computed expectations.
module tb_multicast_fanout;

  localparam int FCW = 85;
  localparam int PN  = 6;

  logic              clk;
  logic              rst;
  logic [FCW-1:0]    in;
  logic [PN-1:0]     in_dst_mask;
  logic              in_valid;
  logic              in_avail;
  logic [PN*FCW-1:0] out;
  logic [PN-1:0]     out_valid;
  logic [PN-1:0]     out_avail;
  logic              drop_zero_mask;
  logic [15:0]       sent_count;

  int total = 0;
  int bad   = 0;

  multicast_fanout #(
    .ValidBitPos(81),
    .lg_numprocs(3),
    .PORT_NUM(6),
    .DEPTH(4),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in(in),
    .in_dst_mask(in_dst_mask),
    .in_valid(in_valid),
    .in_avail(in_avail),
    .out(out),
    .out_valid(out_valid),
    .out_avail(out_avail),
    .drop_zero_mask(drop_zero_mask),
    .sent_count(sent_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FCW-1:0] mkf(input logic [7:0] k);
    return (FCW'(1) << 81) | (FCW'(k) << 40) | FCW'(k);
  endfunction

  function automatic logic [FCW-1:0] lane(input logic [PN*FCW-1:0] v, input int p);
    return v[p*FCW +: FCW];
  endfunction

  logic [FCW-1:0] f1, fa, fb;

  initial begin
    rst = 1'b0; in = '0; in_dst_mask = '0; in_valid = 1'b0; out_avail = '0;
    f1 = (FCW'(1) << 81) | FCW'(8'hA5);
    fa = mkf(8'h3C);
    fb = mkf(8'hC3);
    tick(); tick();
    chk("rst_in_avail", 128'(in_avail), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_sent", 128'(sent_count), 128'(0));
    chk("rst_drop", 128'(drop_zero_mask), 128'(0));
    chk("rst_out", 128'(out == '0), 128'(1));
    rst = 1'b1;
    tick();
    chk("post_rst_in_avail", 128'(in_avail), 128'(1));

    // single flit to lanes 0 and 2
    out_avail = 6'b111111;
    in = f1; in_dst_mask = 6'b000101; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("single_valid", 128'(out_valid), 128'(6'b000101));
    chk("single_lane0", 128'(lane(out, 0)), 128'(f1));
    chk("single_lane2", 128'(lane(out, 2)), 128'(f1));
    chk("single_lane1", 128'(lane(out, 1)), 128'(0));
    tick();
    chk("single_done", 128'(out_valid), 128'(0));
    chk("single_sent", 128'(sent_count), 128'(1));

    // staggered acceptance
    out_avail = 6'b000011;
    in = mkf(8'h11); in_dst_mask = 6'b111111; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("stag_valid0", 128'(out_valid), 128'(6'b111111));
    tick();
    chk("stag_valid1", 128'(out_valid), 128'(6'b111100));
    chk("stag_sent1", 128'(sent_count), 128'(1));
    chk("stag_lane5_hold", 128'(lane(out, 5)), 128'(mkf(8'h11)));
    chk("stag_lane0_off", 128'(lane(out, 0)), 128'(0));
    out_avail = 6'b111100;
    tick();
    chk("stag_valid2", 128'(out_valid), 128'(0));
    chk("stag_sent2", 128'(sent_count), 128'(2));

    // fill to full under backpressure
    out_avail = '0;
    in_dst_mask = 6'b111111; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in = mkf(8'(8'h20 + k));
      tick();
    end
    chk("full_in_avail", 128'(in_avail), 128'(0));
    in = mkf(8'h24);
    tick();
    chk("full_hold_avail", 128'(in_avail), 128'(0));
    chk("full_head", 128'(lane(out, 0)), 128'(mkf(8'h20)));
    out_avail = 6'b111111;
    tick();
    chk("drain_avail", 128'(in_avail), 128'(1));
    chk("drain_f1", 128'(lane(out, 3)), 128'(mkf(8'h21)));
    chk("drain_sent", 128'(sent_count), 128'(3));
    tick();
    in_valid = 1'b0;
    chk("drain_f2", 128'(lane(out, 0)), 128'(mkf(8'h22)));
    tick();
    chk("drain_f3", 128'(lane(out, 5)), 128'(mkf(8'h23)));
    tick();
    chk("drain_f4", 128'(lane(out, 1)), 128'(mkf(8'h24)));
    chk("drain_f4_valid", 128'(out_valid), 128'(6'b111111));
    tick();
    chk("drain_empty", 128'(out_valid), 128'(0));
    chk("drain_sent_all", 128'(sent_count), 128'(7));

    // zero mask is consumed and flagged
    in = mkf(8'h55); in_dst_mask = '0; in_valid = 1'b1;
    #1;
    chk("zero_in_avail", 128'(in_avail), 128'(1));
    tick();
    in_valid = 1'b0;
    chk("zero_drop", 128'(drop_zero_mask), 128'(1));
    chk("zero_valid", 128'(out_valid), 128'(0));
    tick();
    chk("zero_drop_clr", 128'(drop_zero_mask), 128'(0));
    chk("zero_sent", 128'(sent_count), 128'(7));

    // back-to-back, no bubble
    out_avail = 6'b100001;
    in = fa; in_dst_mask = 6'b000001; in_valid = 1'b1;
    tick();
    chk("b2b_a_valid", 128'(out_valid), 128'(6'b000001));
    chk("b2b_a_lane0", 128'(lane(out, 0)), 128'(fa));
    in = fb; in_dst_mask = 6'b100000;
    tick();
    in_valid = 1'b0;
    chk("b2b_b_valid", 128'(out_valid), 128'(6'b100000));
    chk("b2b_b_lane5", 128'(lane(out, 5)), 128'(fb));
    chk("b2b_lane0_off", 128'(lane(out, 0)), 128'(0));
    tick();
    chk("b2b_empty", 128'(out_valid), 128'(0));
    chk("b2b_sent", 128'(sent_count), 128'(9));

    // async reset while serving
    out_avail = '0;
    in_dst_mask = 6'b010000; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in = mkf(8'(8'h70 + k));
      tick();
    end
    in_valid = 1'b0;
    chk("mid_valid", 128'(out_valid), 128'(6'b010000));
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_out", 128'(out == '0), 128'(1));
    chk("mid_rst_sent", 128'(sent_count), 128'(0));
    chk("mid_rst_avail", 128'(in_avail), 128'(0));
    #1 rst = 1'b1;
    tick();
    chk("post_mid_avail", 128'(in_avail), 128'(1));
    out_avail = 6'b111111;
    tick(); tick();
    chk("post_mid_valid", 128'(out_valid), 128'(0));
    chk("post_mid_sent", 128'(sent_count), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
